// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared port ids and default widths for the data-memory arbiter
package dmem_arb_pkg;
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_H = 1'b1;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the arbiter
//   req/we/addr/wdata  requester -> arbiter
//   gnt/stall/rvalid/rdata  arbiter -> requester
interface dmem_arbiter_if #(
    parameter int ADDR_W = dmem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = dmem_arb_pkg::DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              stall;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    modport master (output req, we, addr, wdata, input gnt, stall, rvalid, rdata);
    modport slave (input req, we, addr, wdata, output gnt, stall, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with same-cycle grant
//   clk, rst_n  clock, async active-low reset
//   req[1:0]    requests indexed by port id
//   gnt[1:0]    one-hot (or zero) grant
module rr_arb2 import dmem_arb_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;
    // ptr names the favoured port; grants are forced low while in reset
    assign gnt[PORT_C] = rst_n & req[PORT_C] & (~req[PORT_H] | ptr == PORT_C);
    assign gnt[PORT_H] = rst_n & req[PORT_H] & (~req[PORT_C] | ptr == PORT_H);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= PORT_C;
        else if (|gnt)
            ptr <= gnt[PORT_C] ? PORT_H : PORT_C;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between core (c) and host (h)
//   clk, rst_n     clock, async active-low reset
//   c, h           requester ports (dmem_arbiter_if.slave)
//   mem_*          memory strobe/write/address/data, mem_rdata valid 1 cycle after a read
//   conflict_cnt   saturating count of cycles with both requests high
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     c,
    dmem_arbiter_if.slave     h,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);
    logic [1:0]        req, gnt;
    logic              rd_pend, rd_owner;
    logic [DATA_W-1:0] c_hold, h_hold;
    assign req = {h.req, c.req};
    rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt));
    assign c.gnt = gnt[PORT_C];
    assign h.gnt = gnt[PORT_H];
    assign c.stall = c.req & ~c.gnt;
    assign h.stall = h.req & ~h.gnt;
    always_comb begin
        mem_en = |gnt;
        mem_we = gnt[PORT_H] ? h.we : gnt[PORT_C] ? c.we : 1'b0;
        mem_addr = gnt[PORT_H] ? h.addr : gnt[PORT_C] ? c.addr : '0;
        mem_wdata = gnt[PORT_H] ? h.wdata : gnt[PORT_C] ? c.wdata : '0;
    end
    // read data is routed live during rvalid, otherwise each port keeps its last return
    assign c.rvalid = rd_pend & (rd_owner == PORT_C);
    assign h.rvalid = rd_pend & (rd_owner == PORT_H);
    assign c.rdata = c.rvalid ? mem_rdata : c_hold;
    assign h.rdata = h.rvalid ? mem_rdata : h_hold;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_owner <= PORT_C;
            c_hold <= '0;
            h_hold <= '0;
            conflict_cnt <= '0;
        end else begin
            rd_pend <= mem_en & ~mem_we;
            if (mem_en)
                rd_owner <= gnt[PORT_H] ? PORT_H : PORT_C;
            if (c.rvalid)
                c_hold <= mem_rdata;
            if (h.rvalid)
                h_hold <= mem_rdata;
            if (&req && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
endmodule
